// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder between NREQ requesters.
// Ports: clk, rst (async high), req, x_bus/y_bus (packed operands),
//        gnt (one-hot), owner, busy, done (pulse), sum_out (W+1 bits).

module full_add #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   s
);

    // Explicit carry chain, one bit per stage.
    always_comb begin
        logic cy;
        cy = 1'b0;
        s  = '0;
        for (int i = 0; i < W; i++) begin
            s[i] = a[i] ^ b[i] ^ cy;
            cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        s[W] = cy;
    end

endmodule

module adder_arbiter #(
    parameter int NREQ   = 4,
    parameter int W      = 4,
    parameter int SETTLE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*W-1:0]         x_bus,
    input  logic [NREQ*W-1:0]         y_bus,
    output logic [NREQ-1:0]           gnt,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy,
    output logic                      done,
    output logic [W:0]                sum_out
);

    localparam int IW = $clog2(NREQ);
    localparam logic [3:0] CNT_INIT =
        (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [W-1:0]    x_q, x_d;
    logic [W-1:0]    y_q, y_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [W:0]      sum_q, sum_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic [W:0]      fa_sum;

    logic            hi_found;
    logic [IW-1:0]   hi_idx;
    logic [IW-1:0]   lo_idx;
    logic [IW-1:0]   win_idx;
    logic [W-1:0]    win_x;
    logic [W-1:0]    win_y;

    full_add #(.W(W)) u_add (
        .a (x_q),
        .b (y_q),
        .s (fa_sum)
    );

    // Round-robin pick: lowest requester above last, else lowest overall.
    // Descending loops leave the lowest matching index in place.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (IW'(i) > last_q)) begin
                hi_found = 1'b1;
                hi_idx   = IW'(i);
            end
            if (req[i]) begin
                lo_idx = IW'(i);
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        win_x = '0;
        win_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == win_idx) begin
                win_x = x_bus[i*W +: W];
                win_y = y_bus[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    x_d     = win_x;
                    y_d     = win_y;
                    owner_d = win_idx;
                    last_d  = win_idx;
                    for (int i = 0; i < NREQ; i++) begin
                        gnt_d[i] = (IW'(i) == win_idx);
                    end
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (SETTLE == 0) begin
                    sum_d   = fa_sum;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    sum_d   = fa_sum;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        // Flags follow the next state so they line up with it.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= IW'(NREQ - 1);
            owner_q <= '0;
            gnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sum_out = sum_q;

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one 4-bit ripple-carry adder (`full_add`) between NREQ requesters.
- Each requester presents its own pair of operands and a request line.
- The block picks a winner round-robin, latches the winner's operands into the adder, waits a programmable settle time, then returns a registered 5-bit sum with a one-cycle done pulse.
- It sits between the switch/operand sources and the LED/result sinks.

Parameters:
- NREQ, 4: number of requesters (2..8).
- W, 4: operand width; fixed to match the shared adder.
- SETTLE, 1: extra cycles allowed for carry ripple before the sum is captured (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request, level-sensitive.
- x_bus  input  NREQ*W  packed X operands; requester i uses bits [i*W+W-1 : i*W].
- y_bus  input  NREQ*W  packed Y operands; same packing as x_bus.
- gnt  output  NREQ  one-hot grant, held for the whole operation.
- owner  output  clog2(NREQ)  index of the current or last winner.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse; sum_out is valid for owner.
- sum_out  output  W+1  registered sum; bit W is the carry out.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE.
  - gnt = 0, owner = 0, busy = 0, done = 0, sum_out = 0.
  - Operand registers = 0.
  - Round-robin pointer last = NREQ-1, so req[0] has top priority first.
- Reset mid-operation aborts the operation: no done pulse, partial result discarded.
- States: IDLE, LOAD, WAIT, DONE. All outputs are registered.
- IDLE:
  - If req is nonzero, choose the winner: the first set bit searching last+1, last+2, ... modulo NREQ.
  - Capture that requester's x and y into the operand registers, set owner and last to the winner, set the gnt bit, then go to LOAD.
  - If req is zero, stay in IDLE.
- LOAD: one cycle; the adder inputs are driven from the operand registers.
  - SETTLE = 0: go to DONE.
  - SETTLE > 0: go to WAIT with the counter = SETTLE-1.
- WAIT: decrement the counter. At 0, go to DONE.
- Sum capture: sum_out is loaded from the adder output on the transition into DONE.
- DONE:
  - done = 1 for exactly this cycle, gnt still asserted.
  - Next state is IDLE; gnt clears on entering IDLE.
- Latency: req seen in IDLE at cycle t → gnt high t+1 .. t+2+SETTLE, done at t+2+SETTLE.
- Back-to-back throughput: one operation every 3+SETTLE cycles.
- Requests and operands:
  - req and operands are sampled only in IDLE.
  - Changes to x_bus, y_bus or req during LOAD/WAIT/DONE do not affect the operation in flight.
  - Dropping req mid-operation does not abort it; done still pulses.
- Re-requests: a requester still holding req after its done competes again. The pointer has moved past it, so every other pending requester is served first (no starvation).
- Holding sum_out: it holds its value until the next DONE capture. It is not cleared in IDLE.
- Width rule: sum_out = x + y, zero-extended to W+1 bits. The maximum 15+15 = 30 gives 5'b11110, with no overflow loss.
- No error state. Unused pointer values are impossible because last is always a valid index.

Test Plan:
- Reset: assert rst mid-clock with req=4'b1111 → gnt, busy, done, sum_out all 0 immediately. Release with req=0 → IDLE for 10 cycles, busy=0.
- Single request, SETTLE=1: req=4'b0010, x1=9, y1=8 at cycle t → gnt=4'b0010 for t+1..t+3, owner=1, done pulse at t+3 only, sum_out=5'd17 from t+3 on.
- All four requesting continuously, operands xi=i, yi=i+1 → done every 4 cycles, owners 0,1,2,3,0, sums 1,3,5,7,1. Exactly one gnt bit set at any time.
- Boundary sums: x=15, y=15 → sum_out=5'd30 (carry bit 1). x=0, y=0 → 5'd0. x=8, y=8 → 5'd16.
- Disturbance: req[2] drops and x2 changes from 3 to 12 during WAIT (x2=3, y2=4 at grant) → done still pulses, sum_out=5'd7. Asserting rst in WAIT → no done pulse, and the next grant goes to req[0] when req=4'b0101.
- SETTLE=0 build: single request at t → done at t+2. Back-to-back period is 3 cycles.
